// File: rtl/hilo_pkg.sv
// hilo_pkg: shared constants, operation encoding and decode helpers for the
// HI/LO special-register unit (hilo_acc / hilo_mul).
package hilo_pkg;

  localparam int OP_W        = 3;
  localparam int HILO_DATA_W = 32;

  // Operation encoding on op_code; all eight values are defined.
  typedef enum logic [OP_W-1:0] {
    OP_NOP     = 3'd0,
    OP_WR_BOTH = 3'd1,
    OP_WR_HI   = 3'd2,
    OP_WR_LO   = 3'd3,
    OP_MADD    = 3'd4,
    OP_MADDU   = 3'd5,
    OP_MSUB    = 3'd6,
    OP_MSUBU   = 3'd7
  } op_e;

  // True for the four multiply-accumulate operations.
  function automatic logic op_is_acc(input op_e op);
    return (op == OP_MADD) || (op == OP_MADDU) ||
           (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  // True when the accumulate treats its operands as two's complement.
  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  // True when the accumulate subtracts the product from HI:LO.
  function automatic logic op_is_sub(input op_e op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  // True when the operation writes HI directly from hi_i.
  function automatic logic op_writes_hi(input op_e op);
    return (op == OP_WR_BOTH) || (op == OP_WR_HI);
  endfunction

  // True when the operation writes LO directly from lo_i.
  function automatic logic op_writes_lo(input op_e op);
    return (op == OP_WR_BOTH) || (op == OP_WR_LO);
  endfunction

endpackage

// File: rtl/hilo_mul.sv
// hilo_mul: stage 1 of the accumulate path. Forms the signed or unsigned
// DATA_W x DATA_W product and latches it with the subtract/valid flags.
module hilo_mul
  import hilo_pkg::*;
#(
  parameter int DATA_W = HILO_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_valid,
  input  logic [OP_W-1:0]       op_code,
  input  logic [DATA_W-1:0]     src_a,
  input  logic [DATA_W-1:0]     src_b,
  input  logic                  flush,
  output logic [2*DATA_W-1:0]   p_reg,
  output logic                  p_sub,
  output logic                  p_valid
);

  localparam int ACC_W = 2 * DATA_W;

  op_e              op;
  logic             accept;
  logic             sgn;
  logic [ACC_W-1:0] a_ext;
  logic [ACC_W-1:0] b_ext;
  logic [ACC_W-1:0] prod;

  assign op = op_e'(op_code);

  // Decode the operand extension and whether an accumulate enters stage 1.
  always_comb begin
    sgn    = op_is_signed(op);
    accept = op_valid && op_is_acc(op) && !flush;
  end

  // Extend both operands to the full product width; the truncated 2W-bit
  // product of the extended operands equals the signed or unsigned product.
  always_comb begin
    a_ext = sgn ? {{DATA_W{src_a[DATA_W-1]}}, src_a} : {{DATA_W{1'b0}}, src_a};
    b_ext = sgn ? {{DATA_W{src_b[DATA_W-1]}}, src_b} : {{DATA_W{1'b0}}, src_b};
    prod  = a_ext * b_ext;
  end

  // Stage-1 register: product and flags captured when an accumulate is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_reg   <= '0;
      p_sub   <= 1'b0;
      p_valid <= 1'b0;
    end else begin
      p_valid <= accept;
      if (accept) begin
        p_reg <= prod;
        p_sub <= op_is_sub(op);
      end
    end
  end

endmodule

// File: rtl/hilo_acc.sv
// hilo_acc: HI/LO special registers with a two-stage multiply-accumulate path.
// Optional feature macro HILO_BYPASS_EN: when defined, hi_o/lo_o present the
// value to be committed at the next edge instead of the register contents.
module hilo_acc
  import hilo_pkg::*;
#(
  parameter int DATA_W = HILO_DATA_W
) (
  input  logic                cpu_clk_50M,
  input  logic                cpu_rst,
  input  logic                op_valid,
  input  logic [OP_W-1:0]     op_code,
  input  logic [DATA_W-1:0]   hi_i,
  input  logic [DATA_W-1:0]   lo_i,
  input  logic [DATA_W-1:0]   src_a,
  input  logic [DATA_W-1:0]   src_b,
  input  logic                flush,
  output logic                busy,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o
);

  localparam int ACC_W = 2 * DATA_W;

  op_e               op;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] hi_nxt;
  logic [DATA_W-1:0] lo_nxt;
  logic [ACC_W-1:0]  p_reg;
  logic              p_sub;
  logic              p_valid;
  logic [ACC_W-1:0]  acc_sum;

  assign op = op_e'(op_code);

  hilo_mul #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk      (cpu_clk_50M),
    .rst      (cpu_rst),
    .op_valid (op_valid),
    .op_code  (op_code),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .p_reg    (p_reg),
    .p_sub    (p_sub),
    .p_valid  (p_valid)
  );

  // Stage-2 add/subtract of the latched product into HI:LO, modulo 2^(2W).
  always_comb begin
    if (p_sub) acc_sum = {hi_q, lo_q} - p_reg;
    else       acc_sum = {hi_q, lo_q} + p_reg;
  end

  // Merge: the stage-2 result lands first, then a same-cycle write overrides
  // only the half (or halves) it names, giving program order at one edge.
  always_comb begin
    hi_nxt = hi_q;
    lo_nxt = lo_q;
    if (p_valid) begin
      hi_nxt = acc_sum[ACC_W-1:DATA_W];
      lo_nxt = acc_sum[DATA_W-1:0];
    end
    if (op_valid && op_writes_hi(op)) hi_nxt = hi_i;
    if (op_valid && op_writes_lo(op)) lo_nxt = lo_i;
  end

  // HI/LO registers; reset discards everything, including a pending commit.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_nxt;
      lo_q <= lo_nxt;
    end
  end

  // busy mirrors the stage-2 valid, which is already registered.
  always_comb begin
    busy = p_valid;
  end

`ifdef HILO_BYPASS_EN
  // Forward the value the next edge will commit; during reset that is zero.
  always_comb begin
    hi_o = cpu_rst ? '0 : hi_nxt;
    lo_o = cpu_rst ? '0 : lo_nxt;
  end
`else
  // Reads come straight from the registers; readers stall on busy.
  always_comb begin
    hi_o = hi_q;
    lo_o = lo_q;
  end
`endif

endmodule

// File: tb/tb_hilo_acc.sv
// tb_hilo_acc: randomized and directed checks of hilo_acc against a
// value-level model (HI:LO as one 64-bit number plus a pending delta).
module tb_hilo_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  op_code = 3'd0;
  logic [31:0] hi_i = '0;
  logic [31:0] lo_i = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hilo_acc #(.DATA_W(32)) dut (
    .cpu_clk_50M (clk),
    .cpu_rst     (rst),
    .op_valid    (op_valid),
    .op_code     (op_code),
    .hi_i        (hi_i),
    .lo_i        (lo_i),
    .src_a       (src_a),
    .src_b       (src_b),
    .flush       (flush),
    .busy        (busy),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  // Model state: architectural HI:LO and one delta waiting to be added.
  logic [63:0] m_hilo = '0;
  bit          pend_v = 1'b0;
  logic [63:0] pend_delta = '0;
  bit          model_ok = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Value HI:LO will hold after the coming edge, from the current inputs.
  function automatic logic [63:0] next_hilo();
    logic [63:0] v;
    v = m_hilo;
    if (pend_v) v = v + pend_delta;
    if (op_valid) begin
      case (op_code)
        3'd1: v = {hi_i, lo_i};
        3'd2: v[63:32] = hi_i;
        3'd3: v[31:0] = lo_i;
        default: ;
      endcase
    end
    return v;
  endfunction

  // Amount an accumulate adds to HI:LO (negated for the subtract forms).
  function automatic logic [63:0] acc_delta(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sp;
    logic [63:0] d;
    if (op == 3'd4 || op == 3'd6) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      d  = sp;
    end else begin
      d = {32'd0, a} * {32'd0, b};
    end
    if (op == 3'd6 || op == 3'd7) d = 64'd0 - d;
    return d;
  endfunction

  // Model update at every active edge.
  always @(posedge clk) begin
    logic [63:0] v;
    if (rst) begin
      m_hilo   = '0;
      pend_v   = 1'b0;
      model_ok = 1'b1;
    end else begin
      v = next_hilo();
      if (op_valid && op_code[2] && !flush) begin
        pend_v     = 1'b1;
        pend_delta = acc_delta(op_code, src_a, src_b);
      end else begin
        pend_v = 1'b0;
      end
      m_hilo = v;
    end
  end

  // Compare process: mid-cycle, after inputs for the next edge are applied.
  always @(negedge clk) begin
    logic [63:0] exp;
    #1;
    if (model_ok) begin
`ifdef HILO_BYPASS_EN
      exp = rst ? 64'd0 : next_hilo();
`else
      exp = m_hilo;
`endif
      chk("busy", {63'd0, busy}, {63'd0, pend_v});
      chk("hi_o", {32'd0, hi_o}, {32'd0, exp[63:32]});
      chk("lo_o", {32'd0, lo_o}, {32'd0, exp[31:0]});
    end
  end

  task automatic cyc(input logic r, input logic v, input logic [2:0] op,
                     input logic [31:0] h, input logic [31:0] l,
                     input logic [31:0] a, input logic [31:0] b, input logic f);
    @(negedge clk);
    rst = r; op_valid = v; op_code = op;
    hi_i = h; lo_i = l; src_a = a; src_b = b; flush = f;
  endtask

  task automatic nop(input logic f);
    cyc(1'b0, 1'b1, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, f);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held two cycles, outputs zero.
    cyc(1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    #2;
    chk("rst_hi", {32'd0, hi_o}, 64'd0);
    chk("rst_lo", {32'd0, lo_o}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);

    cyc(1'b0, 1'b1, 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 32'h0, 1'b0);
    nop(1'b0); #2;
    chk("wr_hi", {32'd0, hi_o}, 64'h1234_5678);
    chk("wr_lo", {32'd0, lo_o}, 64'h9ABC_DEF0);

    // Signed MADD -1 x 5 from zero.
    cyc(1'b0, 1'b1, 3'd1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 3'd4, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'd5, 1'b0);
    nop(1'b0); #2;
    chk("madd_busy", {63'd0, busy}, 64'd1);
`ifdef HILO_BYPASS_EN
    chk("madd_bypass_lo", {32'd0, lo_o}, 64'hFFFF_FFFB);
`endif
    nop(1'b0); #2;
    chk("madd_busy_end", {63'd0, busy}, 64'd0);
    chk("madd_hi", {32'd0, hi_o}, 64'hFFFF_FFFF);
    chk("madd_lo", {32'd0, lo_o}, 64'hFFFF_FFFB);

    // Back-to-back unsigned: MADDU max x max then MSUBU 1 x 1.
    cyc(1'b0, 1'b1, 3'd1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 3'd5, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    cyc(1'b0, 1'b1, 3'd7, 32'h0, 32'h0, 32'd1, 32'd1, 1'b0); #2;
    chk("b2b_busy1", {63'd0, busy}, 64'd1);
    nop(1'b0); #2;
    chk("b2b_busy2", {63'd0, busy}, 64'd1);
    nop(1'b0); #2;
    chk("b2b_hi", {32'd0, hi_o}, 64'hFFFF_FFFE);
    chk("b2b_lo", {32'd0, lo_o}, 64'h0000_0000);

    // Wrap with a same-cycle WR_HI merge.
    cyc(1'b0, 1'b1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 3'd5, 32'h0, 32'h0, 32'd1, 32'd1, 1'b0);
    cyc(1'b0, 1'b1, 3'd2, 32'hAAAA_AAAA, 32'h0, 32'h0, 32'h0, 1'b0);
    nop(1'b0); #2;
    chk("merge_hi", {32'd0, hi_o}, 64'hAAAA_AAAA);
    chk("merge_lo", {32'd0, lo_o}, 64'h0000_0000);

    // Flush in the accept cycle cancels; flush one cycle later does not.
    cyc(1'b0, 1'b1, 3'd1, 32'h0, 32'd100, 32'h0, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 3'd4, 32'h0, 32'h0, 32'd3, 32'd4, 1'b1);
    nop(1'b0); #2;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    nop(1'b0); #2;
    chk("flush_lo", {32'd0, lo_o}, 64'd100);
    cyc(1'b0, 1'b1, 3'd4, 32'h0, 32'h0, 32'd3, 32'd4, 1'b0);
    nop(1'b1); #2;
    chk("late_flush_busy", {63'd0, busy}, 64'd1);
    nop(1'b0); #2;
    chk("late_flush_lo", {32'd0, lo_o}, 64'd112);

    // Reset on the edge where a MADD would commit.
    cyc(1'b0, 1'b1, 3'd4, 32'h0, 32'h0, 32'd3, 32'd4, 1'b0);
    cyc(1'b1, 1'b1, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    nop(1'b0); #2;
    chk("rstmid_hi", {32'd0, hi_o}, 64'd0);
    chk("rstmid_lo", {32'd0, lo_o}, 64'd0);
    chk("rstmid_busy", {63'd0, busy}, 64'd0);
    nop(1'b0); #2;
    chk("rstmid_late", {32'd0, lo_o}, 64'd0);

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 2000; i++) begin
      logic [2:0] op;
      op = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0), op,
          pick(), pick(), pick(), pick(), ($urandom_range(0, 3) == 0));
    end
    nop(1'b0);
    nop(1'b0);
    nop(1'b0);
    #2;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_acc.md
# hilo_acc

Parametrised HI/LO special-register unit for the MIPS core: holds the HI and LO registers and extends plain HI/LO writes with a two-stage multiply-accumulate path (MADD/MADDU/MSUB/MSUBU). It sits beside the write-back stage. MTHI/MTLO/MULT results write directly. Accumulate ops multiply in stage 1 and add into HI:LO in stage 2. Reads feed MFHI/MFLO, with a busy flag so the pipeline can stall on a pending accumulate.

## Interface
- DATA_W, 32, width of HI, LO and each multiplier operand
- cpu_clk_50M  input  1  sole clock, rising edge
- cpu_rst  input  1  synchronous reset, active-high
- op_valid  input  1  operation present this cycle
- op_code  input  3  see Operation; encodings in hilo_pkg
- hi_i  input  DATA_W  HI write data
- lo_i  input  DATA_W  LO write data
- src_a  input  DATA_W  multiplicand (rs)
- src_b  input  DATA_W  multiplier (rt)
- flush  input  1  kill an accumulate still in stage 1
- busy  output  1  accumulate held in stage 2 (commit at next edge)
- hi_o  output  DATA_W  HI read value
- lo_o  output  DATA_W  LO read value

## Operation
- op_code values:
  - NOP=0
  - WR_BOTH=1
  - WR_HI=2
  - WR_LO=3
  - MADD=4 (signed)
  - MADDU=5
  - MSUB=6 (signed)
  - MSUBU=7
- Writes (1–3) commit at the edge where op_valid=1. Unwritten halves hold.
- Accumulate (4–7) uses two stages:
  - Edge t: product src_a×src_b (2·DATA_W bits, signed or unsigned per op) is latched into p_reg. The sub/valid flags are also latched, and busy goes to 1.
  - Edge t+1: {HI,LO} <= {HI,LO} ± p_reg, modulo 2^(2·DATA_W). Wrap-around is silent, with no overflow flag.
- Back-to-back accumulates are fully pipelined. The op at t+1 enters stage 1 while the op at t commits, so busy stays 1.
- If a write arrives while stage 2 commits, both act at the same edge in program order:
  - The write's half or halves take hi_i/lo_i.
  - Any unwritten half takes the accumulate result.
- flush=1 cancels only an op entering stage 1 in that same cycle. A stage-2 commit is never cancelled. flush together with a write op has no effect on the write.
- NOP and op_valid=0 change nothing in the registers. Stage 2 still drains.
- Unused opcode encodings do not exist, since all 8 values are defined.

## Timing
- Reset (edge with cpu_rst=1):
  - HI=0, LO=0, p_reg=0, stage valid=0, busy=0.
  - Any in-flight accumulate is discarded.
  - Reset has priority over all inputs.
- Write latency: 1 edge. hi_o/lo_o show the new value in the cycle after the edge.
- Accumulate latency: 2 edges from accept to the HI/LO update.
- busy is registered. It is 1 in the cycle after an accepted, unflushed accumulate and 0 otherwise.
- No ready signal: an op is accepted every cycle.
- Stall rule: consumers must stall MFHI/MFLO while busy=1, unless bypass is compiled in.

## Configuration
- HILO_BYPASS_EN defined:
  - hi_o/lo_o are driven combinationally with the value that will be committed at the next edge. That value includes the stage-2 result merged with any same-cycle write.
  - busy is still generated, but readers need not stall.
- HILO_BYPASS_EN undefined:
  - hi_o/lo_o come directly from the HI/LO registers.
  - Readers must honour busy.
- Register contents and commit timing are identical in both builds.

## Structure
- hilo_pkg: op_code localparams, the OP_W=3 constant and the DATA_W default.
- Sub-module hilo_mul: signed/unsigned DATA_W×DATA_W multiplier plus the stage-1 register, outputting p_reg and stage valid.
- hilo_acc holds:
  - the HI/LO registers
  - the add/subtract unit
  - the write/accumulate merge
  - the bypass mux

## Test plan
- Reset and write order:
  - Hold cpu_rst 2 cycles, then WR_BOTH hi_i=0x1234_5678, lo_i=0x9ABC_DEF0.
  - Required: outputs are 0 during reset, then read the written values one cycle after the edge.
- MADD signed:
  - From HI:LO=0, MADD src_a=0xFFFF_FFFF (−1), src_b=5.
  - Required: busy=1 for one cycle, then HI=0xFFFF_FFFF, LO=0xFFFF_FFFB.
- Back-to-back unsigned accumulates:
  - MADDU 0xFFFF_FFFF×0xFFFF_FFFF, then immediately MSUBU 1×1.
  - Required: HI=0xFFFF_FFFE, LO=0x0000_0000 after the second commit.
  - busy stays 1 across both ops.
- Wrap and merge:
  - Preload HI:LO=0xFFFF_FFFF_FFFF_FFFF, then MADDU 1×1. In the commit cycle also issue WR_HI hi_i=0xAAAA_AAAA.
  - Required: HI=0xAAAA_AAAA, LO=0x0000_0000.
- Flush:
  - MADD 3×4 with flush=1.
  - Required: busy stays 0 and HI:LO is unchanged.
  - Repeat with flush asserted one cycle later. Required: the commit happens, so LO increases by 12.
- Reset mid-op:
  - MADD accepted, then cpu_rst=1 on the next edge.
  - Required: HI=LO=0 and busy=0, with no late commit.
  - Under HILO_BYPASS_EN, additionally check that lo_o shows the stage-2 result in the busy cycle.
